// File: rtl/lag_est_pkg.sv
// -----------------------------------------------------------------------------
// lag_est_pkg
// Shared definitions for the lag estimator and the variable-delay stage it
// drives: FSM state encoding, accumulator width and lag-index width helpers.
// The lag-index width helper is the single source of truth for the width of
// the estimator's `number` output and the delay stage's select input.
// -----------------------------------------------------------------------------
package lag_est_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    MAC,
    CMP,
    DONE
  } state_e;

  // Full-precision correlation width: 2N-bit product summed WIN times.
  function automatic int acc_width(input int n, input int win);
    return 2 * n + $clog2(win);
  endfunction

  // Width of a lag index 0..max_delay-1 (never narrower than one bit).
  function automatic int lag_width(input int max_delay);
    return (max_delay > 1) ? $clog2(max_delay) : 1;
  endfunction

endpackage

// File: rtl/lag_mac.sv
// -----------------------------------------------------------------------------
// lag_mac
// Signed multiply-accumulate for one correlation lag.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous accumulator clear (wins over en_i)
//   en_i       : add a_i*b_i this cycle
//   a_i, b_i   : signed N-bit operands
//   acc_o      : value used for best-lag selection; the signed sum, or its
//                magnitude when LAG_ABS_PEAK_EN is defined
// Optional feature macro: LAG_ABS_PEAK_EN (magnitude output).
// -----------------------------------------------------------------------------
module lag_mac #(
  parameter int N     = 16,
  parameter int ACC_W = 38
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [N-1:0]     a_i,
  input  logic signed [N-1:0]     b_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [2*N-1:0]   prod;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  assign prod = a_i * b_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_q + ACC_W'(prod);  // signed cast sign-extends
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

`ifdef LAG_ABS_PEAK_EN
  // ACC_W has headroom above the worst-case magnitude, so negation cannot wrap.
  assign acc_o = acc_q[ACC_W-1] ? -acc_q : acc_q;
`else
  assign acc_o = acc_q;
`endif

endmodule

// File: rtl/lag_estimator.sv
// -----------------------------------------------------------------------------
// lag_estimator
// Brute-force cross-correlation lag search. Captures WIN (ref, sig) pairs,
// computes C(d) = sum_k ref[k-d]*sig[k] for d = 0..MAX_DELAY-1 (one lag per
// WIN+1 cycles) and reports the lag with the largest correlation.
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : begin a new estimate (IDLE only)
//   in_valid      : ref_in/sig_in valid (CAPTURE only)
//   ref_in/sig_in : signed reference / delayed samples
//   busy          : high outside IDLE
//   done          : one-cycle pulse when number/peak are updated
//   number        : best lag, drives the delay stage's select
//   number_valid  : number belongs to the most recently completed run
//   peak          : correlation at the chosen lag
// Optional feature macro: LAG_ABS_PEAK_EN (select on |C(d)|, peak = |C|).
// -----------------------------------------------------------------------------
module lag_estimator
  import lag_est_pkg::*;
#(
  parameter int N         = 16,
  parameter int MAX_DELAY = 32,
  parameter int WIN       = 64,
  // Derived widths; leave at their defaults.
  parameter int ACC_W     = acc_width(N, WIN),
  parameter int LW        = lag_width(MAX_DELAY)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [N-1:0]         ref_in,
  input  logic [N-1:0]         sig_in,
  output logic                 busy,
  output logic                 done,
  output logic [LW-1:0]        number,
  output logic                 number_valid,
  output logic [ACC_W-1:0]     peak
);

  localparam int KW = (WIN > 1) ? $clog2(WIN) : 1;

  state_e                  state_q;
  logic [KW-1:0]           k_q;
  logic [LW-1:0]           d_q, best_lag_q, number_q;
  logic signed [ACC_W-1:0] best_q, peak_q, cmp_val;
  logic                    busy_q, done_q, nv_q;

  logic signed [N-1:0]     ref_buf_q [WIN];
  logic signed [N-1:0]     sig_buf_q [WIN];

  logic [KW-1:0]           d_ext, rd_idx;
  logic                    mac_en, mac_clr;

  // ref is read d samples behind sig; indices below d contribute nothing,
  // so the wrapped read address there is harmless because the add is gated.
  assign d_ext   = KW'(d_q);
  assign rd_idx  = k_q - d_ext;
  assign mac_en  = (state_q == MAC) && (k_q >= d_ext);
  assign mac_clr = (state_q == CMP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN; i++) begin
        ref_buf_q[i] <= '0;
        sig_buf_q[i] <= '0;
      end
    end else if (state_q == CAPTURE && in_valid) begin
      ref_buf_q[k_q] <= ref_in;
      sig_buf_q[k_q] <= sig_in;
    end
  end

  lag_mac #(.N(N), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (ref_buf_q[rd_idx]),
    .b_i   (sig_buf_q[k_q]),
    .acc_o (cmp_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      d_q        <= '0;
      best_q     <= '0;
      best_lag_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      nv_q       <= 1'b0;
      number_q   <= '0;
      peak_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= CAPTURE;
          busy_q  <= 1'b1;
          nv_q    <= 1'b0;
          k_q     <= '0;
        end
        CAPTURE: if (in_valid) begin
          if (k_q == KW'(WIN - 1)) begin
            state_q <= MAC;
            k_q     <= '0;
            d_q     <= '0;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        MAC: begin
          if (k_q == KW'(WIN - 1)) begin
            state_q <= CMP;
            k_q     <= '0;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        CMP: begin
          // Strict compare: on ties the earliest (smallest) lag is kept.
          if (d_q == '0 || cmp_val > best_q) begin
            best_q     <= cmp_val;
            best_lag_q <= d_q;
          end
          if (d_q == LW'(MAX_DELAY - 1)) begin
            state_q <= DONE;
          end else begin
            d_q     <= d_q + LW'(1);
            state_q <= MAC;
          end
        end
        DONE: begin
          number_q <= best_lag_q;
          peak_q   <= best_q;
          done_q   <= 1'b1;
          nv_q     <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign number       = number_q;
  assign number_valid = nv_q;
  assign peak         = peak_q;

endmodule

// File: tb/tb_lag_estimator.sv
module tb_lag_estimator;

  localparam int N         = 16;
  localparam int MAX_DELAY = 32;
  localparam int WIN       = 64;
  localparam int ACC_W     = 2 * N + $clog2(WIN);
  localparam int LW        = $clog2(MAX_DELAY);
  localparam int LAT       = WIN + MAX_DELAY * (WIN + 1) + 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                in_valid = 1'b0;
  logic [N-1:0]        ref_in = '0;
  logic [N-1:0]        sig_in = '0;
  logic                busy, done, number_valid;
  logic [LW-1:0]       number;
  logic [ACC_W-1:0]    peak;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  logic signed [N-1:0] ref_v [WIN];
  logic signed [N-1:0] sig_v [WIN];

  lag_estimator #(.N(N), .MAX_DELAY(MAX_DELAY), .WIN(WIN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .ref_in       (ref_in),
    .sig_in       (sig_in),
    .busy         (busy),
    .done         (done),
    .number       (number),
    .number_valid (number_valid),
    .peak         (peak)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_vecs();
    for (int k = 0; k < WIN; k++) begin
      ref_v[k] = '0;
      sig_v[k] = '0;
    end
  endtask

  // One estimate: start, capture (optionally every other cycle), wait for
  // done. abort_at > 0 asserts reset that many cycles after capture ends.
  task automatic run_est(input string tag, input bit gaps, input bit extra_start,
                         input int abort_at, input int exp_lat);
    time t0;
    int  prev_done;
    bit  seen;
    @(posedge clk); #1 start = 1'b1;
    in_valid = 1'b1; ref_in = 16'h1111; sig_in = 16'h2222;  // must be ignored
    @(posedge clk); #1 start = 1'b0;
    t0 = $time;
    check({tag, "_busy_start"}, 64'(busy), 1);
    check({tag, "_nv_clear"}, 64'(number_valid), 0);
    prev_done = done_cnt;
    for (int k = 0; k < WIN; k++) begin
      in_valid = 1'b1; ref_in = ref_v[k]; sig_in = sig_v[k];
      @(posedge clk); #1;
      if (gaps && k != WIN - 1) begin
        in_valid = 1'b0; ref_in = 16'h7abc; sig_in = 16'h7abc;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0; ref_in = '0; sig_in = '0;
    seen = 1'b0;
    for (int c = 0; c < 4000 && !seen; c++) begin
      if (abort_at > 0 && c == abort_at) break;
      start = (extra_start && c == 20);
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    if (abort_at > 0) begin
      rst_n = 1'b0;
      #1;
      check({tag, "_rst_busy"}, 64'(busy), 0);
      check({tag, "_rst_done"}, 64'(done), 0);
      check({tag, "_rst_number"}, 64'(number), 0);
      check({tag, "_rst_nv"}, 64'(number_valid), 0);
      check({tag, "_rst_peak"}, $signed(peak), 0);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
    end else begin
      check({tag, "_done_seen"}, 64'(seen), 1);
      check({tag, "_latency"}, 64'(($time - t0) / 10), exp_lat);
      check({tag, "_busy_end"}, 64'(busy), 0);
      check({tag, "_nv_set"}, 64'(number_valid), 1);
      repeat (5) @(posedge clk);
      #1 check({tag, "_done_pulses"}, 64'(done_cnt - prev_done), 1);
    end
  endtask

  initial begin
    longint sumsq;
    logic signed [N-1:0] v;

    #12;
    check("reset_busy", 64'(busy), 0);
    check("reset_done", 64'(done), 0);
    check("reset_number", 64'(number), 0);
    check("reset_nv", 64'(number_valid), 0);
    check("reset_peak", $signed(peak), 0);
    #5 rst_n = 1'b1;

    // 1: impulse at k=5 in ref, k=12 in sig -> lag 7
    clear_vecs();
    ref_v[5] = 16'sd1000; sig_v[12] = 16'sd1000;
    run_est("impulse", 1'b0, 1'b0, 0, LAT);
    check("impulse_number", 64'(number), 7);
    check("impulse_peak", $signed(peak), 1000000);

    // 2: identity, nonzero samples -> lag 0, peak = energy
    sumsq = 0;
    for (int k = 0; k < WIN; k++) begin
      v = 16'((k * 73) % 2001 - 1000);
      if (v == 0) v = 16'sd7;
      ref_v[k] = v; sig_v[k] = v;
      sumsq += longint'(v) * longint'(v);
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("identity_number_held", 64'(number), 7);
    // previous start was accepted just now; let that run finish normally
    for (int k = 0; k < WIN; k++) begin
      in_valid = 1'b1; ref_in = ref_v[k]; sig_in = sig_v[k];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int c = 0; c < 4000 && done !== 1'b1; c++) begin
      @(posedge clk); #1;
    end
    check("identity_number", 64'(number), 0);
    check("identity_peak", $signed(peak), sumsq);
    check("identity_nv", 64'(number_valid), 1);

    // 3: all zero -> ties resolve to lag 0
    clear_vecs();
    run_est("zero", 1'b0, 1'b0, 0, LAT);
    check("zero_number", 64'(number), 0);
    check("zero_peak", $signed(peak), 0);

    // 4: anti-phase
    clear_vecs();
    ref_v[5] = 16'sd1000; sig_v[8] = -16'sd1000;
    run_est("anti", 1'b0, 1'b0, 0, LAT);
`ifdef LAG_ABS_PEAK_EN
    check("anti_number", 64'(number), 3);
    check("anti_peak", $signed(peak), 1000000);
`else
    check("anti_number", 64'(number), 0);
    check("anti_peak", $signed(peak), 0);
`endif

    // 5: alternate-cycle capture, stray start during MAC
    clear_vecs();
    ref_v[5] = 16'sd1000; sig_v[12] = 16'sd1000;
    run_est("stress", 1'b1, 1'b1, 0, LAT + WIN - 1);
    check("stress_number", 64'(number), 7);
    check("stress_peak", $signed(peak), 1000000);

    // 6: reset mid-MAC, then a clean rerun
    run_est("abort", 1'b0, 1'b0, 200, LAT);
    run_est("rerun", 1'b0, 1'b0, 0, LAT);
    check("rerun_number", 64'(number), 7);
    check("rerun_peak", $signed(peak), 1000000);

    // 7: full-scale negative samples -> C(0) = 64 * 2^30
    for (int k = 0; k < WIN; k++) begin
      ref_v[k] = 16'sh8000; sig_v[k] = 16'sh8000;
    end
    run_est("full", 1'b0, 1'b0, 0, LAT);
    check("full_number", 64'(number), 0);
    check("full_peak", $signed(peak), longint'(1) << 36);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
